// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard controller sitting between ID and the fetch stage.
//   Resolves load-use hazards, branch/jr operands resolved in ID (including
//   the two-cycle branch-on-load case via a RUN/HOLD FSM) and the structural
//   conflict on the single memory port shared by fetch and MEM loads/stores.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     When defined, adds saturating 32-bit performance counters
//     Perf_Stalls (cycles with a data stall) and Perf_Flushes (cycles with
//     IF_Flush asserted outside reset).
//
//   Ports:
//     Clock, Reset          rising-edge clock, async active-high reset
//     ID_Rs, ID_Rt          ID source registers
//     ID_UsesRt             ID instruction reads Rt
//     ID_BranchCmp          ID instruction compares registers / jr target
//     ID_PCSrc              PC source from decode (0 = sequential)
//     EX_MemRead/RegWrite/Rd  EX-stage load flag, write flag, destination
//     MEM_MemRead/MemWrite    MEM-stage memory port users
//     MEM_Rd, MEM_Rt          MEM destination / store-data source register
//     WB_RegWrite, WB_Rd      WB write flag and destination
//     IF_PCWrite            PC register enable
//     IF_Write              IF/ID register enable
//     IF_Flush              IF/ID loads NOP
//     ID_Bubble             zero ID/EX control fields
//     IF_ForC               store data select: 0 = MEM_RtData, 1 = WB_WriteData
//     HZ_State              FSM state: 0 = RUN, 1 = HOLD
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_W    = 5,
  parameter int PC_SRC_W = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [REG_W-1:0]    ID_Rs,
  input  logic [REG_W-1:0]    ID_Rt,
  input  logic                ID_UsesRt,
  input  logic                ID_BranchCmp,
  input  logic [PC_SRC_W-1:0] ID_PCSrc,
  input  logic                EX_MemRead,
  input  logic                EX_RegWrite,
  input  logic [REG_W-1:0]    EX_Rd,
  input  logic                MEM_MemRead,
  input  logic                MEM_MemWrite,
  input  logic [REG_W-1:0]    MEM_Rd,
  input  logic [REG_W-1:0]    MEM_Rt,
  input  logic                WB_RegWrite,
  input  logic [REG_W-1:0]    WB_Rd,
  output logic                IF_PCWrite,
  output logic                IF_Write,
  output logic                IF_Flush,
  output logic                ID_Bubble,
  output logic                IF_ForC,
  output logic                HZ_State
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         Perf_Stalls,
  output logic [31:0]         Perf_Flushes
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  // A producer register matches the ID instruction if it is nonzero and
  // feeds either source operand actually read by ID.
  function automatic logic reg_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             uses_rt
  );
    return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  logic ex_match;
  logic mem_match;
  logic lu_hz;      // load-use
  logic ba_hz;      // branch operand from an EX ALU result
  logic bl_hz;      // branch operand from an EX load (two stall cycles)
  logic bm_hz;      // branch operand from a MEM load
  logic data_stall;
  logic struct_conflict;

  always_comb begin
    ex_match  = reg_match(EX_Rd,  ID_Rs, ID_Rt, ID_UsesRt);
    mem_match = reg_match(MEM_Rd, ID_Rs, ID_Rt, ID_UsesRt);

    lu_hz = EX_MemRead && ex_match;
    ba_hz = ID_BranchCmp && EX_RegWrite && !EX_MemRead && ex_match;
    bl_hz = ID_BranchCmp && EX_MemRead && ex_match;
    bm_hz = ID_BranchCmp && MEM_MemRead && mem_match;

    // Detection only contributes in RUN; HOLD stalls unconditionally.
    if (state == HOLD)
      data_stall = 1'b1;
    else
      data_stall = lu_hz || ba_hz || bl_hz || bm_hz;

    struct_conflict = MEM_MemRead || MEM_MemWrite;
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // Next state and fetch/decode control
  always_comb begin
    state_nxt  = state;
    IF_PCWrite = 1'b1;
    IF_Write   = 1'b1;
    IF_Flush   = 1'b0;
    ID_Bubble  = 1'b0;

    unique case (state)
      RUN:     if (bl_hz) state_nxt = HOLD;
      HOLD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    if (Reset) begin
      IF_PCWrite = 1'b0;
      IF_Write   = 1'b1;
      IF_Flush   = 1'b1;
      ID_Bubble  = 1'b1;
    end else if (data_stall) begin
      // Branch redirect is ignored; it re-resolves once operands are ready.
      IF_PCWrite = 1'b0;
      IF_Write   = 1'b0;
      IF_Flush   = 1'b0;
      ID_Bubble  = 1'b1;
    end else if (ID_PCSrc != '0) begin
      // Taken redirect squashes the wrong-path fetch even when the memory
      // port was also stolen; the PC still advances to the target.
      IF_PCWrite = 1'b1;
      IF_Write   = 1'b1;
      IF_Flush   = 1'b1;
    end else if (struct_conflict) begin
      // Fetch lost to MEM; hold PC so the same address refetches.
      IF_PCWrite = 1'b0;
      IF_Write   = 1'b1;
      IF_Flush   = 1'b1;
    end
  end

  // Store data forwarding from WB into the MEM store path.
  always_comb begin
    IF_ForC = 1'b0;
    if (!Reset)
      IF_ForC = MEM_MemWrite && WB_RegWrite && (WB_Rd != '0) && (WB_Rd == MEM_Rt);
  end

  assign HZ_State = (state == HOLD);

`ifdef HAZARD_PERF_CNT_EN
  // Counters saturate rather than wrap; the else branch never runs while
  // Reset is high, so flushes forced by reset are not counted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Perf_Stalls  <= '0;
      Perf_Flushes <= '0;
    end else begin
      if (data_stall && (Perf_Stalls != '1))
        Perf_Stalls <= Perf_Stalls + 32'd1;
      if (IF_Flush && (Perf_Flushes != '1))
        Perf_Flushes <= Perf_Flushes + 32'd1;
    end
  end
`endif

endmodule
